r200dmem_resp: RTL and testbench
================================

Name: r200dmem_resp

Overview:
- Data-memory responder on the r200 load/store bus. It is the memory-side end of the bus that the MEM stage drives as initiator.
- Accepts one request at a time over a valid/ready handshake and holds it in a word-organised SRAM model with configurable wait states.
- Performs RV32I byte, halfword and word stores and loads, including sign and zero extension, and flags illegal accesses.
- Returns every result over a second valid/ready response channel, so the pipeline can stall on memory.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2^ADDR_W words of 32 bits.
- WAIT_CYC, 2, extra wait cycles between acceptance and response; 0 is legal.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is taken from the low bits for byte and halfword stores.
- req_func3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  32  load result, already extended; 0 for stores and for errors.
- rsp_err  out  1  access was illegal; no memory side effect occurred.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (rst=0, asynchronous):
  - State goes to IDLE; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; the wait counter is cleared.
  - SRAM contents are not cleared.
  - A request in flight when reset asserts is dropped and no partial write occurs.
- IDLE:
  - req_ready=1.
  - When req_valid && req_ready at an edge, capture we/addr/wdata/func3.
  - Go to WAIT if WAIT_CYC>0, otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - The counter counts WAIT_CYC cycles; on the last cycle the state goes to RESP.
- Entry into RESP (the single edge at which the access executes):
  - The legality check is evaluated.
  - For a legal store, the write to the array is committed.
  - For a legal load, the word is read and rsp_rdata is produced.
  - rsp_valid rises in the same cycle.
- Latency: rsp_valid is first high WAIT_CYC+1 cycles after the accept edge.
- RESP:
  - rsp_valid=1, and rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready at an edge.
  - On that edge the state goes to IDLE and rsp_valid drops.
  - req_ready=0 throughout RESP, so req_valid is ignored; the initiator must hold it.
  - Maximum throughput is one access per WAIT_CYC+2 cycles.
- Legality (rsp_err=1 if any of the following holds):
  - func3 is 011, 110 or 111.
  - A store has func3 100 or 101.
  - A halfword access has addr[0]≠0.
  - A word access has addr[1:0]≠0.
  - addr[31:ADDR_W+2] is non-zero.
  - On error there is no write and rsp_rdata=0.
- Addressing: word index = addr[ADDR_W+1:2]; byte lane = addr[1:0].
- Stores:
  - sb writes lane addr[1:0] with wdata[7:0].
  - sh writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - sw writes all four lanes.
  - Untouched lanes are preserved; rsp_rdata=0.
- Loads:
  - The selected lane(s) are shifted to the LSBs.
  - b and h are sign-extended from bit 7 and bit 15 respectively.
  - bu and hu are zero-extended.
  - w is passed through unchanged.
- A store followed by a load to the same address always returns the stored data, because accesses are strictly serialised.

Test Plan:
- Reset: assert rst=0 mid-WAIT after a store sw 0x11223344 to 0x0 → immediately req_ready=1, rsp_valid=0; a later lw 0x0 returns the old contents, not 0x11223344.
- Word store and load with WAIT_CYC=2: sw 0xDEADBEEF at 0x40, then lw 0x40 → each rsp_valid first high 3 cycles after its accept edge; the load gives rdata=0xDEADBEEF, err=0.
- Byte and halfword stores and loads:
  - sb 0x80 at 0x41 over 0x00000000 gives the word 0x00008000.
  - lb 0x41 returns 0xFFFFFF80; lbu 0x41 returns 0x00000080.
  - sh 0x8001 at 0x42; lh 0x42 returns 0xFFFF8001; lhu 0x42 returns 0x00008001.
- Errors, each giving err=1, rdata=0 and memory unchanged:
  - lw at 0x42 (misaligned word).
  - sh at 0x43 (misaligned halfword).
  - func3=011.
  - store with func3=100.
  - lw at 0x00001000 with ADDR_W=10 (out of range).
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; a second req_valid is not accepted until the response handshake completes.
- WAIT_CYC=0 back-to-back: accept at edge N → rsp_valid at N+1; with rsp_ready=1 the next request is accepted at N+2.

Source files
------------

// File: rtl/r200dmem_resp.sv
// r200dmem_resp: r200 load/store bus data-memory responder.
// Serialised valid/ready request/response with a word SRAM model and WAIT_CYC wait states.
module r200dmem_resp #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int CW = WAIT_CYC > 1 ? $clog2(WAIT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYC > 0 ? WAIT_CYC - 1 : 0);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d, err_q, err_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [2:0]      func3_q, func3_d;
    logic [31:0]     mem [2**ADDR_W];

    logic            accept, exec, wr_en, a_we, bad;
    logic [31:0]     a_addr, a_wdata, word, shifted, load_val, wrep, wr_word;
    logic [2:0]      a_f;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [ADDR_W-1:0] idx;

    // With WAIT_CYC=0 the access executes on the accept edge, straight from the request bus.
    assign accept  = state_q == IDLE && req_valid;
    assign exec    = (accept && WAIT_CYC == 0) || (state_q == WAIT && cnt_q == LAST);
    assign a_we    = state_q == IDLE ? req_we    : we_q;
    assign a_addr  = state_q == IDLE ? req_addr  : addr_q;
    assign a_wdata = state_q == IDLE ? req_wdata : wdata_q;
    assign a_f     = state_q == IDLE ? req_func3 : func3_q;
    assign lane    = a_addr[1:0];
    assign idx     = a_addr[ADDR_W+1:2];
    assign bad     = a_f == 3'b011 || a_f[2:1] == 2'b11 || (a_we && a_f[2])
                   || (a_f[1:0] == 2'b01 && a_addr[0]) || (a_f[1:0] == 2'b10 && |lane)
                   || |a_addr[31:ADDR_W+2];
    assign word     = mem[idx];
    assign shifted  = word >> {lane, 3'b000};
    assign load_val = a_f[1:0] == 2'b00 ? {{24{~a_f[2] & shifted[7]}}, shifted[7:0]}
                    : a_f[1:0] == 2'b01 ? {{16{~a_f[2] & shifted[15]}}, shifted[15:0]} : word;
    assign be   = a_f[1:0] == 2'b00 ? 4'b0001 << lane : a_f[1:0] == 2'b01 ? 4'b0011 << lane : 4'b1111;
    assign wrep = a_f[1:0] == 2'b00 ? {4{a_wdata[7:0]}} : a_f[1:0] == 2'b01 ? {2{a_wdata[15:0]}} : a_wdata;
    // Reset gates the write so an in-flight store can never land while rst is low.
    assign wr_en = rst && exec && a_we && !bad;

    always_comb begin
        wr_word = word;
        for (int i = 0; i < 4; i++)
            wr_word[8*i +: 8] = be[i] ? wrep[8*i +: 8] : word[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= wr_word;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IDLE: if (req_valid) state_d = WAIT_CYC == 0 ? RESP : WAIT;
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = RESP;
            end
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d    = accept ? req_we    : we_q;
        addr_d  = accept ? req_addr  : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
        func3_d = accept ? req_func3 : func3_q;
        rdata_d = exec ? ((bad || a_we) ? '0 : load_val) : rdata_q;
        err_d   = exec ? bad : err_q;
    end

    always_comb begin
        req_ready = state_q == IDLE;
        rsp_valid = state_q == RESP;
        rsp_rdata = rdata_q;
        rsp_err   = err_q;
    end
endmodule

// File: tb/tb_r200dmem_resp.sv
// tb_r200dmem_resp: table vectors, randomized traffic against a byte-array reference model,
// and hand sequences for backpressure, reset mid-access and zero-wait back-to-back.
module tb_r200dmem_resp;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    logic        req_valid = 0, req_ready, req_we = 0, rsp_valid, rsp_ready = 0, rsp_err;
    logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
    logic [2:0]  req_func3 = 0;
    logic        z_req_valid = 0, z_req_ready, z_req_we = 0, z_rsp_valid, z_rsp_ready = 1, z_rsp_err;
    logic [31:0] z_req_addr = 0, z_req_wdata = 0, z_rsp_rdata;
    logic [2:0]  z_req_func3 = 0;

    r200dmem_resp #(.ADDR_W(10), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    r200dmem_resp #(.ADDR_W(10), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_func3(z_req_func3),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    int vecs = 0, errs = 0;
    logic [7:0] rmem [4096];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    // Byte-addressed reference: legality from width/alignment/range rules, little-endian bytes.
    function automatic void ref_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [2:0] f, output logic [31:0] rd, output logic er);
        int sz;
        logic [31:0] v;
        sz = (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
        er = f == 3'd3 || f == 3'd6 || f == 3'd7 || (we && f >= 3'd4) || (a % sz != 0) || a >= 32'd4096;
        rd = 0;
        if (!er) begin
            if (we) begin
                for (int k = 0; k < sz; k++) rmem[a[11:0] + 12'(k)] = wd[8*k +: 8];
            end else begin
                v = 0;
                for (int k = 0; k < sz; k++) v = v | (32'(rmem[a[11:0] + 12'(k)]) << (8 * k));
                if (f <= 3'd1 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
                rd = v;
            end
        end
    endfunction

    task automatic send(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f);
        int n = 0;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_func3 = f; req_valid = 1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_before_accept", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] rd, output logic er, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 30);
        chk("rsp_valid_arrives", {31'b0, rsp_valid}, 1);
        rd = rsp_rdata;
        er = rsp_err;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'b0, rsp_valid}, 1);
            chk("hold_rsp_rdata", rsp_rdata, rd);
            chk("hold_req_ready", {31'b0, req_ready}, 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        chk("post_hs_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("post_hs_req_ready", {31'b0, req_ready}, 1);
    endtask

    task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f,
                       input int hold, output logic [31:0] rd, output logic er);
        int lat;
        send(we, a, wd, f);
        get_rsp(hold, rd, er, lat);
        chk("latency", lat, 3);
    endtask

    initial begin
        vec_t        tbl [16];
        logic [31:0] rd, mrd, a, wd;
        logic        er, mer, we;
        logic [2:0]  f;
        int          lat, n;

        tbl[0]  = '{1'b1, 32'h40,   32'hDEADBEEF, 3'b010, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h40,   32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h40,   32'h0,        3'b010, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h41,   32'hABCDEF80, 3'b000, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h40,   32'h0,        3'b010, 32'h00008000, 1'b0};
        tbl[5]  = '{1'b0, 32'h41,   32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
        tbl[6]  = '{1'b0, 32'h41,   32'h0,        3'b100, 32'h00000080, 1'b0};
        tbl[7]  = '{1'b1, 32'h42,   32'h12348001, 3'b001, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 32'h42,   32'h0,        3'b001, 32'hFFFF8001, 1'b0};
        tbl[9]  = '{1'b0, 32'h42,   32'h0,        3'b101, 32'h00008001, 1'b0};
        tbl[10] = '{1'b0, 32'h42,   32'h0,        3'b010, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 32'h43,   32'h0000FFFF, 3'b001, 32'h0,        1'b1};
        tbl[12] = '{1'b0, 32'h40,   32'h0,        3'b011, 32'h0,        1'b1};
        tbl[13] = '{1'b1, 32'h40,   32'h000000FF, 3'b100, 32'h0,        1'b1};
        tbl[14] = '{1'b0, 32'h1000, 32'h0,        3'b010, 32'h0,        1'b1};
        tbl[15] = '{1'b0, 32'h40,   32'h0,        3'b010, 32'h80018000, 1'b0};

        #2 rst = 0;
        #1;
        chk("reset_req_ready", {31'b0, req_ready}, 1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 0);
        repeat (2) @(negedge clk);
        rst = 1;

        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            ref_access(1'b1, 32'(i * 4), wd, 3'b010, mrd, mer);
            txn(1'b1, 32'(i * 4), wd, 3'b010, 0, rd, er);
            chk("init_err", {31'b0, er}, 0);
        end

        for (int i = 0; i < 16; i++) begin
            ref_access(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].f, mrd, mer);
            txn(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].f, i % 2, rd, er);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), {31'b0, er}, {31'b0, tbl[i].er});
        end

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
            wd = $urandom;
            ref_access(we, a, wd, f, mrd, mer);
            txn(we, a, wd, f, $urandom_range(0, 2), rd, er);
            chk($sformatf("rand%0d_rdata", i), rd, mrd);
            chk($sformatf("rand%0d_err", i), {31'b0, er}, {31'b0, mer});
        end

        // Backpressure with a second request held on the bus.
        ref_access(1'b0, 32'h40, 0, 3'b010, mrd, mer);
        send(1'b0, 32'h40, 0, 3'b010);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 30);
        chk("bp_rsp_valid", {31'b0, rsp_valid}, 1);
        req_we = 0; req_addr = 32'h44; req_func3 = 3'b010; req_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'b0, rsp_valid}, 1);
            chk("bp_hold_rdata", rsp_rdata, mrd);
            chk("bp_hold_err", {31'b0, rsp_err}, 0);
            chk("bp_hold_req_ready", {31'b0, req_ready}, 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        chk("bp_after_hs_valid", {31'b0, rsp_valid}, 0);
        chk("bp_after_hs_ready", {31'b0, req_ready}, 1);
        @(posedge clk);
        #1 req_valid = 0;
        chk("bp_second_accepted", {31'b0, req_ready}, 0);
        ref_access(1'b0, 32'h44, 0, 3'b010, mrd, mer);
        get_rsp(0, rd, er, lat);
        chk("bp_second_rdata", rd, mrd);
        chk("bp_second_lat", lat, 3);

        // Reset in the middle of a store's wait phase drops it.
        ref_access(1'b1, 32'h0, 32'hCAFEF00D, 3'b010, mrd, mer);
        txn(1'b1, 32'h0, 32'hCAFEF00D, 3'b010, 0, rd, er);
        txn(1'b0, 32'h4, 0, 3'b010, 0, rd, er);
        send(1'b1, 32'h0, 32'h11223344, 3'b010);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_mid_req_ready", {31'b0, req_ready}, 1);
        chk("rst_mid_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_mid_rsp_rdata", rsp_rdata, 0);
        chk("rst_mid_rsp_err", {31'b0, rsp_err}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1;
        txn(1'b0, 32'h0, 0, 3'b010, 0, rd, er);
        chk("rst_dropped_store", rd, 32'hCAFEF00D);

        // Zero-wait instance: accept at N, response at N+1, next accept at N+2.
        @(negedge clk);
        z_req_we = 1; z_req_addr = 32'h10; z_req_wdata = 32'hA5A50F0F; z_req_func3 = 3'b010; z_req_valid = 1;
        chk("z_ready_idle", {31'b0, z_req_ready}, 1);
        @(posedge clk);
        #1 z_req_we = 0;
        @(negedge clk);
        chk("z_store_valid", {31'b0, z_rsp_valid}, 1);
        chk("z_store_req_ready", {31'b0, z_req_ready}, 0);
        chk("z_store_err", {31'b0, z_rsp_err}, 0);
        chk("z_store_rdata", z_rsp_rdata, 0);
        @(negedge clk);
        chk("z_hs_valid", {31'b0, z_rsp_valid}, 0);
        chk("z_hs_ready", {31'b0, z_req_ready}, 1);
        @(posedge clk);
        #1 z_req_valid = 0;
        @(negedge clk);
        chk("z_load_valid", {31'b0, z_rsp_valid}, 1);
        chk("z_load_rdata", z_rsp_rdata, 32'hA5A50F0F);
        @(negedge clk);
        chk("z_load_done", {31'b0, z_rsp_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
